utils_div_seq: RTL

- Sequential radix-2 restoring integer divider. It is the inverse-arithmetic companion of the multiplier carry-lookahead utilities.
- Used by the TPU post-processing path for requantisation scale division and averaging.
- Accepts one dividend/divisor pair per transaction over a valid/ready handshake. Returns quotient and remainder after a fixed iteration count.
- Supports signed or unsigned operation, selected per transaction.

---
 rtl/utils_div_pkg.sv | 11 +
 rtl/utils_div_step.sv | 23 ++
 rtl/utils_div_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/utils_div_pkg.sv
// Shared constants for the sequential restoring divider.
package utils_div_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // Sliced to the operand width by the user.
  localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/utils_div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module utils_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  assign w_shift  = {i_rem, i_bit};
  assign w_diff   = w_shift - {1'b0, i_div};
  // Subtrahend MSB is zero, so a borrow occurs only when the minuend MSB is clear and the result MSB is set.
  assign w_borrow = w_diff[WIDTH] & ~w_shift[WIDTH];
  assign o_qbit   = ~w_borrow;
  assign o_rem    = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/utils_div_seq.sv
// Sequential radix-2 restoring divider, signed or unsigned per transaction, valid/ready on both sides.
module utils_div_seq
  import utils_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dz;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Magnitudes fit in WIDTH unsigned bits, including that of the most negative value.
  assign w_dvd_neg  = in_signed & in_dividend[WIDTH-1];
  assign w_dsr_neg  = in_signed & in_divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -in_dividend : in_dividend;
  assign w_dsr_mag  = w_dsr_neg ? -in_divisor : in_divisor;
  assign w_div_zero = (in_divisor == '0);
  assign w_ovf      = in_signed && (in_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (in_divisor == '1);

  utils_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_div  (r_dsr),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};
  assign w_q_fix    = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (in_valid) begin
            if (w_div_zero) begin
              r_q_out <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
              r_r_out <= in_dividend;
              r_dz    <= 1'b1;
              r_state <= DIV_DONE;
            end else if (w_ovf) begin
              r_q_out <= in_dividend;
              r_r_out <= '0;
              r_dz    <= 1'b0;
              r_state <= DIV_DONE;
            end else begin
              r_dvd   <= w_dvd_mag;
              r_dsr   <= w_dsr_mag;
              r_rem   <= '0;
              r_quo   <= '0;
              r_neg_q <= w_dvd_neg ^ w_dsr_neg;
              r_neg_r <= w_dvd_neg;
              r_cnt   <= CW'(WIDTH - 1);
              r_state <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          r_dvd <= r_dvd << 1;
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == '0) begin
            r_q_out <= w_q_fix;
            r_r_out <= w_r_fix;
            r_dz    <= 1'b0;
            r_state <= DIV_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DIV_DONE: begin
          if (out_ready) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == DIV_IDLE);
  assign out_valid     = (r_state == DIV_DONE);
  assign busy          = (r_state != DIV_IDLE);
  assign out_quotient  = r_q_out;
  assign out_remainder = r_r_out;
  assign out_div_zero  = r_dz;

endmodule
